// File: rtl/data_mem_if.sv
// Word-wide CPU data-memory request/response bus.
`timescale 1ns/1ps
interface data_mem_if;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_ready;
  logic        data_error;
  logic        busy;

  // CPU side drives requests, observes responses
  modport master (
    output data_read, data_write, data_addr, data_in,
    input  data_out, data_ready, data_error, busy
  );

  // Memory side observes requests, drives responses
  modport slave (
    input  data_read, data_write, data_addr, data_in,
    output data_out, data_ready, data_error, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: services word reads/writes after LATENCY wait
// states and flags misaligned, out-of-range and conflicting requests.
`timescale 1ns/1ps
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input logic       clk,
  input logic       rst,
  data_mem_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             rd_q, rd_d;
  logic             err_q, err_d;
  logic [31:0]      data_out_q, data_out_d;
  logic             ready_q, ready_d;
  logic             error_q, error_d;
  logic             busy_q, busy_d;

  logic             resp_go;
  logic [31:0]      cur_addr;
  logic [31:0]      cur_wdata;
  logic             cur_rd;
  logic             cur_err;
  logic [31:0]      cur_off;
  logic [IDX_W-1:0] cur_idx;

  logic             mem_we_c;
  logic [IDX_W-1:0] mem_idx_c;
  logic [31:0]      mem_wdata_c;

  // Reject misaligned, out-of-window, or simultaneous read+write accesses
  function automatic logic acc_error(input logic [31:0] a, input logic rd, input logic wr);
    logic [31:0] off;
    logic [31:0] word;
    off  = a - BASE_ADDR;
    word = off >> 2;
    return (a[1:0] != 2'b00) || (a < BASE_ADDR) ||
           (word >= 32'(DEPTH_WORDS)) || (rd && wr);
  endfunction

  // Next-state, capture and response logic; the response fires on the edge entering RESP
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    err_d      = err_q;
    data_out_d = data_out_q;
    ready_d    = 1'b0;
    error_d    = 1'b0;
    resp_go    = 1'b0;
    cur_addr   = addr_q;
    cur_wdata  = wdata_q;
    cur_rd     = rd_q;
    cur_err    = err_q;
    mem_we_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.data_read || bus.data_write) begin
          addr_d  = bus.data_addr;
          wdata_d = bus.data_in;
          rd_d    = bus.data_read;
          err_d   = acc_error(bus.data_addr, bus.data_read, bus.data_write);
          if (LATENCY == 0) begin
            // zero wait states: respond on the capture edge from live inputs
            resp_go   = 1'b1;
            cur_addr  = bus.data_addr;
            cur_wdata = bus.data_in;
            cur_rd    = bus.data_read;
            cur_err   = err_d;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) resp_go = 1'b1;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cur_off = cur_addr - BASE_ADDR;
    cur_idx = IDX_W'(cur_off >> 2);

    if (resp_go) begin
      state_d = S_RESP;
      ready_d = 1'b1;
      error_d = cur_err;
      if (cur_err) begin
        if (cur_rd) data_out_d = '0;
      end else if (cur_rd) begin
        data_out_d = mem[cur_idx];
      end else begin
        mem_we_c = 1'b1;
      end
    end

    busy_d      = (state_d != S_IDLE);
    mem_idx_c   = cur_idx;
    mem_wdata_c = cur_wdata;
  end

  // Control and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      err_q      <= 1'b0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      busy_q     <= busy_d;
    end
  end

  // Storage array; not cleared by reset, and no commit while reset is held
  always_ff @(posedge clk) begin
    if (mem_we_c && !rst) mem[mem_idx_c] <= mem_wdata_c;
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_ready = ready_q;
  assign bus.data_error = error_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one instance with LATENCY=2, one with LATENCY=0.
`timescale 1ns/1ps
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_if ba ();
  data_mem_if bb ();

  data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .bus(ba)
  );
  data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .bus(bb)
  );

  int checks = 0;
  int errors = 0;

  task automatic drive(input bit which, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (which) begin
      bb.data_read = rd; bb.data_write = wr; bb.data_addr = a; bb.data_in = d;
    end else begin
      ba.data_read = rd; ba.data_write = wr; ba.data_addr = a; ba.data_in = d;
    end
  endtask

  function automatic logic get_ready(input bit which);
    return which ? bb.data_ready : ba.data_ready;
  endfunction
  function automatic logic get_err(input bit which);
    return which ? bb.data_error : ba.data_error;
  endfunction
  function automatic logic get_busy(input bit which);
    return which ? bb.busy : ba.busy;
  endfunction
  function automatic logic [31:0] get_out(input bit which);
    return which ? bb.data_out : ba.data_out;
  endfunction

  // One request: raise at negedge, count negedges after the capture edge until data_ready
  task automatic access(input bit which, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] dout, output logic err,
                        output int bcnt, output time t_rdy);
    @(negedge clk);
    drive(which, rd, wr, a, d);
    @(posedge clk);
    lat = 99; bcnt = 0; dout = '0; err = 1'b0; t_rdy = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (get_busy(which)) bcnt++;
      if (get_ready(which)) begin
        lat = c; dout = get_out(which); err = get_err(which); t_rdy = $time;
        break;
      end
    end
    drive(which, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({ba.data_ready, ba.data_error, ba.busy, bb.data_ready, bb.data_error, bb.busy} !== 6'b0) begin
        errors++;
        $display("FAIL reset_idle_flags cycle %0d: got %b expected 000000", c,
                 {ba.data_ready, ba.data_error, ba.busy, bb.data_ready, bb.data_error, bb.busy});
      end
      checks++;
      if (ba.data_out !== 32'h0 || bb.data_out !== 32'h0) begin
        errors++;
        $display("FAIL reset_idle_data_out cycle %0d: got %h/%h expected 0", c, ba.data_out, bb.data_out);
      end
    end
  endtask

  task automatic test_latency2();
    int lat, bc; logic [31:0] d; logic e; time t;
    access(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, d, e, bc, t);
    checks++;
    if (lat !== 3 || e !== 1'b0 || bc !== 3) begin
      errors++;
      $display("FAIL l2_write: lat %0d err %b busy %0d, expected 3 0 3", lat, e, bc);
    end
    @(negedge clk);
    checks++;
    if (ba.data_ready !== 1'b0 || ba.busy !== 1'b0) begin
      errors++;
      $display("FAIL l2_ready_one_cycle: ready %b busy %b expected 0 0", ba.data_ready, ba.busy);
    end
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, lat, d, e, bc, t);
    checks++;
    if (lat !== 3 || e !== 1'b0 || bc !== 3) begin
      errors++;
      $display("FAIL l2_read_timing: lat %0d err %b busy %0d, expected 3 0 3", lat, e, bc);
    end
    checks++;
    if (d !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL l2_read_data: got %h expected deadbeef", d);
    end
  endtask

  task automatic test_latency0();
    int lat1, lat2, bc; logic [31:0] d1, d2; logic e1, e2; time t1, t2;
    access(1'b1, 1'b0, 1'b1, 32'h0, 32'h1, lat1, d1, e1, bc, t1);
    access(1'b1, 1'b0, 1'b1, 32'h4, 32'h2, lat2, d2, e2, bc, t2);
    checks++;
    if (lat1 !== 1 || lat2 !== 1 || e1 !== 1'b0 || e2 !== 1'b0 || (t2 - t1) !== 20) begin
      errors++;
      $display("FAIL l0_writes: lat %0d/%0d err %b/%b period %0t, expected 1/1 0/0 20", lat1, lat2, e1, e2, t2 - t1);
    end
    access(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, lat1, d1, e1, bc, t1);
    access(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, lat2, d2, e2, bc, t2);
    checks++;
    if (d1 !== 32'h1 || d2 !== 32'h2) begin
      errors++;
      $display("FAIL l0_read_data: got %h/%h expected 00000001/00000002", d1, d2);
    end
    checks++;
    if (lat1 !== 1 || lat2 !== 1 || bc !== 1 || (t2 - t1) !== 20) begin
      errors++;
      $display("FAIL l0_read_rate: lat %0d/%0d busy %0d period %0t, expected 1/1 1 20", lat1, lat2, bc, t2 - t1);
    end
  endtask

  task automatic test_errors();
    int lat, bc; logic [31:0] d; logic e; time t;
    access(1'b0, 1'b0, 1'b1, 32'h0, 32'h11111111, lat, d, e, bc, t);
    access(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, lat, d, e, bc, t);
    checks++;
    if (d !== 32'h11111111 || e !== 1'b0) begin
      errors++;
      $display("FAIL err_setup_read: got %h err %b expected 11111111 0", d, e);
    end
    access(1'b0, 1'b1, 1'b0, 32'h13, 32'h0, lat, d, e, bc, t);
    checks++;
    if (lat !== 3 || e !== 1'b1 || d !== 32'h0) begin
      errors++;
      $display("FAIL err_misaligned_read: lat %0d err %b data %h expected 3 1 0", lat, e, d);
    end
    access(1'b0, 1'b0, 1'b1, 32'h1000, 32'h55555555, lat, d, e, bc, t);
    checks++;
    if (lat !== 3 || e !== 1'b1) begin
      errors++;
      $display("FAIL err_range_write: lat %0d err %b expected 3 1", lat, e);
    end
    access(1'b0, 1'b1, 1'b1, 32'h0, 32'h77777777, lat, d, e, bc, t);
    checks++;
    if (lat !== 3 || e !== 1'b1 || d !== 32'h0) begin
      errors++;
      $display("FAIL err_both_rw: lat %0d err %b data %h expected 3 1 0", lat, e, d);
    end
    access(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, lat, d, e, bc, t);
    checks++;
    if (d !== 32'h11111111 || e !== 1'b0) begin
      errors++;
      $display("FAIL err_word0_unchanged: got %h err %b expected 11111111 0", d, e);
    end
    access(1'b0, 1'b0, 1'b1, 32'hFFC, 32'h0BADF00D, lat, d, e, bc, t);
    checks++;
    if (e !== 1'b0) begin
      errors++;
      $display("FAIL err_last_word_write: err %b expected 0", e);
    end
    checks++;
    if (ba.data_out !== 32'h11111111) begin
      errors++;
      $display("FAIL data_out_hold_on_write: got %h expected 11111111", ba.data_out);
    end
    access(1'b0, 1'b1, 1'b0, 32'hFFC, 32'h0, lat, d, e, bc, t);
    checks++;
    if (d !== 32'h0BADF00D || e !== 1'b0) begin
      errors++;
      $display("FAIL err_last_word_read: got %h err %b expected 0badf00d 0", d, e);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc; logic [31:0] d; logic e; time t;
    access(1'b0, 1'b0, 1'b1, 32'h20, 32'h12345678, lat, d, e, bc, t);
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, lat, d, e, bc, t);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ba.busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_in_wait: busy %b expected 1", ba.busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({ba.data_ready, ba.data_error, ba.busy} !== 3'b0 || ba.data_out !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: flags %b data %h expected 000 0",
               {ba.data_ready, ba.data_error, ba.busy}, ba.data_out);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, lat, d, e, bc, t);
    checks++;
    if (d !== 32'h12345678 || e !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_not_committed: got %h err %b expected 12345678 0", d, e);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic [31:0] d; logic e; time t;
    logic [9:0] pat;
    logic [31:0] d2;
    access(1'b0, 1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, lat, d, e, bc, t);
    pat = '0;
    d2  = '0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      pat[c-1] = ba.data_ready;
      if (c == 7) begin
        d2 = ba.data_out;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    checks++;
    if (pat !== 10'b00_0100_0100) begin
      errors++;
      $display("FAIL b2b_ready_pattern: got %b expected 0001000100", pat);
    end
    checks++;
    if (d2 !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL b2b_second_data: got %h expected a5a5a5a5", d2);
    end
  endtask

  initial begin
    test_reset();
    test_latency2();
    test_latency0();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
